// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-style core: FETCH/DECODE/EXEC/WB state machine with 64-bit instruction fetch.
// Latency: 4 cycles per instruction with a zero-wait memory, plus one cycle per imem wait cycle.
// Backpressure: FETCH holds imem_req/imem_addr stable until imem_valid; HALT stops fetching until reset.
module mips_multicycle #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 16,  // at most 32: branch/jump targets come from the 32-bit immediate
  parameter int REG_ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_W-1:0]     imem_addr,
  input  logic [63:0]           imem_rdata,
  input  logic                  imem_valid,
  input  logic [REG_ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  zero,
  output logic                  halted,
  output logic                  illegal,
  output logic [31:0]           instret
);

  localparam int NREG      = 1 << REG_ADDR_W;
  localparam int SH_W      = $clog2(DATA_W);
  localparam int FIELD_END = 6 + 3 * REG_ADDR_W;

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SLT  = 6'd6;
  localparam logic [5:0] OP_SLL  = 6'd7;
  localparam logic [5:0] OP_SRL  = 6'd8;
  localparam logic [5:0] OP_ADDI = 6'd9;
  localparam logic [5:0] OP_BEQ  = 6'd10;
  localparam logic [5:0] OP_JMP  = 6'd11;
  localparam logic [5:0] OP_HALT = 6'd63;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched instruction fields
  logic [5:0]            ir_op;
  logic [REG_ADDR_W-1:0] ir_rd;
  logic [REG_ADDR_W-1:0] ir_rs1;
  logic [REG_ADDR_W-1:0] ir_rs2;
  logic [31:0]           ir_imm;

  // Datapath registers between stages
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] res;
  logic [ADDR_W-1:0] npc;

  // Architectural state
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] regs [NREG];

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu;
  logic [ADDR_W-1:0] npc_calc;
  logic              writes_rd;
  logic              op_legal;
  logic              unused_rdata;

  // Bits between the register fields and the immediate carry no meaning.
  assign unused_rdata = &{1'b0, imem_rdata[31:FIELD_END]};

  assign imm_ext   = DATA_W'($signed(ir_imm));
  assign writes_rd = (ir_op >= OP_ADD) && (ir_op <= OP_ADDI);
  assign op_legal  = (ir_op <= OP_JMP) || (ir_op == OP_HALT);

  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);
  assign dbg_rdata = regs[dbg_raddr];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and fetch request; request is gated by reset so it drops the moment reset asserts
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = rst_n;
        if (imem_valid) state_nxt = ST_DECODE;
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_WB;
      ST_WB:     state_nxt = (ir_op == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  // ALU result and next PC, evaluated from the operands latched in DECODE
  always_comb begin
    alu      = '0;
    npc_calc = pc + ADDR_W'(1);
    case (ir_op)
      OP_ADD:  alu = opa + opb;
      OP_SUB:  alu = opa - opb;
      OP_AND:  alu = opa & opb;
      OP_OR:   alu = opa | opb;
      OP_XOR:  alu = opa ^ opb;
      OP_SLT:  alu = ($signed(opa) < $signed(opb)) ? DATA_W'(1) : '0;
      OP_SLL:  alu = opa << opb[SH_W-1:0];
      OP_SRL:  alu = opa >> opb[SH_W-1:0];
      OP_ADDI: alu = opa + imm_ext;
      OP_BEQ:  if (opa == opb) npc_calc = pc + ir_imm[ADDR_W-1:0];
      OP_JMP:  npc_calc = ir_imm[ADDR_W-1:0];
      OP_HALT: npc_calc = pc;
      default: alu = '0;
    endcase
  end

  // Pipeline-internal registers: instruction latch, operand latch, result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_op  <= '0;
      ir_rd  <= '0;
      ir_rs1 <= '0;
      ir_rs2 <= '0;
      ir_imm <= '0;
      opa    <= '0;
      opb    <= '0;
      res    <= '0;
      npc    <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_valid) begin
            ir_op  <= imem_rdata[5:0];
            ir_rd  <= imem_rdata[6 +: REG_ADDR_W];
            ir_rs1 <= imem_rdata[6 + REG_ADDR_W +: REG_ADDR_W];
            ir_rs2 <= imem_rdata[6 + 2 * REG_ADDR_W +: REG_ADDR_W];
            ir_imm <= imem_rdata[63:32];
          end
        end
        ST_DECODE: begin
          opa <= regs[ir_rs1];
          opb <= regs[ir_rs2];
        end
        ST_EXEC: begin
          res <= alu;
          npc <= npc_calc;
        end
        default: ;
      endcase
    end
  end

  // Writeback: register file, PC, zero flag, retire counter and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      instret <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == ST_WB) begin
      pc      <= npc;
      instret <= instret + 32'd1;
      if (writes_rd) begin
        zero <= (res == '0);
        // r0 is never written, so it always reads back as zero
        if (ir_rd != '0) regs[ir_rd] <= res;
      end
      if (!op_legal) illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle with a wait-state memory model and register/fetch scoreboards.
// Each program runs from reset to HALT; results are compared through the debug port and status outputs.
// Memory inserts 0, random 0-3 or fixed 3 wait cycles and drives junk on imem_valid while idle.
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [63:0] imem_rdata;
  logic        imem_valid;
  logic [5:0]  dbg_raddr;
  logic [63:0] dbg_rdata;
  logic        zero;
  logic        halted;
  logic        illegal;
  logic [31:0] instret;

  mips_multicycle #(.DATA_W(64), .ADDR_W(16), .REG_ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .zero(zero), .halted(halted), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  r;
    logic [63:0] v;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_fetch[$];
  logic [63:0] mem [0:65535];
  int          total = 0;
  int          passed = 0;
  int          wait_mode = 0;
  int          total_waits = 0;
  int          addr_bad = 0;
  int          cyc;

  localparam logic [63:0] HALT_WORD = 64'h0000_0000_0000_003F;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] enc(input logic [5:0] op, input logic [5:0] rd,
                                      input logic [5:0] rs1, input logic [5:0] rs2,
                                      input logic [31:0] imm);
    logic [63:0] w;
    w = '0;
    w[5:0]   = op;
    w[11:6]  = rd;
    w[17:12] = rs1;
    w[23:18] = rs2;
    w[63:32] = imm;
    return w;
  endfunction

  task automatic exp_reg(input logic [5:0] r, input logic [63:0] v);
    exp_t e;
    e.r = r;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      dbg_raddr = e.r;
      #1;
      chk($sformatf("reg_r%0d", e.r), dbg_rdata, e.v);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    exp_fetch.delete();
    sb.delete();
  endtask

  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) exp_fetch.push_back(16'(i));
  endtask

  task automatic hold_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    total_waits = 0;
    addr_bad = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_halt(input int max, output int c);
    c = 0;
    while (!halted && c < max) begin
      @(posedge clk);
      #1 c++;
    end
    chk("halt_reached", halted, 1);
  endtask

  task automatic load_prog1();
    clear_mem();
    mem[0] = enc(6'd9, 6'd1, 6'd0, 6'd0, 32'd5);
    mem[1] = enc(6'd9, 6'd2, 6'd0, 6'd0, 32'hFFFF_FFFD);
    mem[2] = enc(6'd1, 6'd3, 6'd1, 6'd2, 32'd0);
    mem[3] = enc(6'd2, 6'd4, 6'd2, 6'd2, 32'd0);
    mem[4] = HALT_WORD;
    push_seq(5);
    exp_reg(6'd1, 64'd5);
    exp_reg(6'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    exp_reg(6'd3, 64'd2);
    exp_reg(6'd4, 64'd0);
  endtask

  // Instruction memory: answers each request after the chosen number of wait cycles
  initial begin
    logic       busy;
    logic [1:0] wait_left;
    logic [15:0] req_addr;
    logic [15:0] ef;
    busy = 1'b0;
    wait_left = '0;
    req_addr = '0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          req_addr = imem_addr;
          case (wait_mode)
            0:       wait_left = 2'd0;
            1:       wait_left = 2'($urandom_range(0, 3));
            default: wait_left = 2'd3;
          endcase
          total_waits += int'(wait_left);
          chk("fetch_expected", 64'(exp_fetch.size() > 0), 1);
          if (exp_fetch.size() > 0) begin
            ef = exp_fetch.pop_front();
            chk("fetch_addr", imem_addr, ef);
          end
        end else if (imem_addr !== req_addr) begin
          addr_bad++;
        end
        if (wait_left == 2'd0) begin
          imem_valid = 1'b1;
          imem_rdata = mem[imem_addr];
          busy = 1'b0;
        end else begin
          imem_valid = 1'b0;
          wait_left = wait_left - 2'd1;
        end
      end else begin
        busy = 1'b0;
        imem_rdata = HALT_WORD;
        imem_valid = (wait_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    dbg_raddr = '0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_imem_req", imem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_instret", instret, 0);
    chk("rst_zero", zero, 0);
    chk("rst_imem_addr", imem_addr, 0);

    // Program 1, zero-wait memory
    load_prog1();
    release_rst();
    run_halt(400, cyc);
    chk("p1_cycles", cyc, 20);
    chk("p1_instret", instret, 5);
    chk("p1_zero", zero, 1);
    chk("p1_req_halt", imem_req, 0);
    chk("p1_pc_halt", imem_addr, 16'd4);
    chk("p1_fetch_left", exp_fetch.size(), 0);
    check_sb();

    // Program 1, random wait states and idle junk on imem_valid
    hold_reset();
    load_prog1();
    wait_mode = 1;
    release_rst();
    run_halt(400, cyc);
    chk("p2_cycles", cyc, 20 + total_waits);
    chk("p2_addr_stable", addr_bad, 0);
    chk("p2_instret", instret, 5);
    chk("p2_zero", zero, 1);
    chk("p2_fetch_left", exp_fetch.size(), 0);
    check_sb();
    wait_mode = 0;

    // Branches, jump and PC wrap in both directions
    hold_reset();
    clear_mem();
    mem[16'h0000] = enc(6'd10, 6'd0, 6'd1, 6'd0, 32'hFFFF_FFFF);
    mem[16'hFFFF] = enc(6'd9, 6'd1, 6'd0, 6'd0, 32'd1);
    mem[16'h0001] = enc(6'd9, 6'd2, 6'd0, 6'd0, 32'd2);
    mem[16'h0002] = enc(6'd9, 6'd3, 6'd0, 6'd0, 32'd0);
    mem[16'h0003] = enc(6'd10, 6'd0, 6'd1, 6'd2, 32'd100);
    mem[16'h0004] = enc(6'd11, 6'd0, 6'd0, 6'd0, 32'h0000_1234);
    mem[16'h1234] = enc(6'd10, 6'd0, 6'd2, 6'd2, 32'h0000_0010);
    mem[16'h1244] = HALT_WORD;
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'hFFFF);
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0001);
    exp_fetch.push_back(16'h0002);
    exp_fetch.push_back(16'h0003);
    exp_fetch.push_back(16'h0004);
    exp_fetch.push_back(16'h1234);
    exp_fetch.push_back(16'h1244);
    exp_reg(6'd1, 64'd1);
    exp_reg(6'd2, 64'd2);
    exp_reg(6'd3, 64'd0);
    release_rst();
    run_halt(400, cyc);
    chk("br_cycles", cyc, 36);
    chk("br_instret", instret, 9);
    chk("br_zero_kept", zero, 1);
    chk("br_pc_halt", imem_addr, 16'h1244);
    chk("br_fetch_left", exp_fetch.size(), 0);
    check_sb();

    // r0 discard, masked shifts, signed compare
    hold_reset();
    clear_mem();
    mem[0] = enc(6'd9, 6'd1, 6'd0, 6'd0, 32'd1);
    mem[1] = enc(6'd9, 6'd6, 6'd0, 6'd0, 32'h41);
    mem[2] = enc(6'd7, 6'd5, 6'd1, 6'd6, 32'd0);
    mem[3] = enc(6'd9, 6'd7, 6'd0, 6'd0, 32'hFFFF_FFFF);
    mem[4] = enc(6'd6, 6'd8, 6'd7, 6'd1, 32'd0);
    mem[5] = enc(6'd8, 6'd10, 6'd7, 6'd6, 32'd0);
    mem[6] = enc(6'd6, 6'd9, 6'd1, 6'd7, 32'd0);
    mem[7] = enc(6'd9, 6'd0, 6'd0, 6'd0, 32'd7);
    mem[8] = HALT_WORD;
    push_seq(9);
    exp_reg(6'd0, 64'd0);
    exp_reg(6'd5, 64'd2);
    exp_reg(6'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_reg(6'd8, 64'd1);
    exp_reg(6'd9, 64'd0);
    exp_reg(6'd10, 64'h7FFF_FFFF_FFFF_FFFF);
    release_rst();
    run_halt(400, cyc);
    chk("sh_instret", instret, 9);
    chk("sh_zero_r0", zero, 0);
    chk("sh_fetch_left", exp_fetch.size(), 0);
    check_sb();

    // Illegal opcode followed by logic ops
    hold_reset();
    clear_mem();
    mem[0] = enc(6'd9, 6'd1, 6'd0, 6'd0, 32'hF0);
    mem[1] = enc(6'd9, 6'd2, 6'd0, 6'd0, 32'h3C);
    mem[2] = enc(6'h20, 6'd1, 6'd1, 6'd2, 32'd5);
    mem[3] = enc(6'd3, 6'd3, 6'd1, 6'd2, 32'd0);
    mem[4] = enc(6'd4, 6'd4, 6'd1, 6'd2, 32'd0);
    mem[5] = enc(6'd5, 6'd5, 6'd1, 6'd2, 32'd0);
    mem[6] = HALT_WORD;
    push_seq(7);
    exp_reg(6'd1, 64'hF0);
    exp_reg(6'd2, 64'h3C);
    exp_reg(6'd3, 64'h30);
    exp_reg(6'd4, 64'hFC);
    exp_reg(6'd5, 64'hCC);
    release_rst();
    run_halt(400, cyc);
    chk("il_illegal", illegal, 1);
    chk("il_instret", instret, 7);
    chk("il_fetch_left", exp_fetch.size(), 0);
    check_sb();

    // Reset during a fetch wait
    hold_reset();
    load_prog1();
    sb.delete();
    exp_fetch.delete();
    exp_fetch.push_back(16'h0000);
    wait_mode = 2;
    release_rst();
    repeat (2) @(posedge clk);
    #1;
    chk("rf_req_before", imem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rf_req_drop", imem_req, 0);
    chk("rf_illegal_clr", illegal, 0);
    chk("rf_instret", instret, 0);
    wait_mode = 0;
    exp_fetch.delete();
    push_seq(5);
    exp_reg(6'd1, 64'd5);
    exp_reg(6'd3, 64'd2);
    release_rst();
    run_halt(400, cyc);
    chk("rf_cycles", cyc, 20);
    check_sb();

    // Reset during writeback of ADD r3
    hold_reset();
    exp_fetch.delete();
    push_seq(5);
    release_rst();
    repeat (11) @(posedge clk);
    #1;
    chk("rw_instret_pre", instret, 2);
    dbg_raddr = 6'd1;
    #1;
    chk("rw_r1_pre", dbg_rdata, 5);
    rst_n = 1'b0;
    #1;
    chk("rw_req", imem_req, 0);
    chk("rw_instret", instret, 0);
    chk("rw_pc", imem_addr, 0);
    chk("rw_r1_clr", dbg_rdata, 0);
    dbg_raddr = 6'd2;
    #1;
    chk("rw_r2_clr", dbg_rdata, 0);
    exp_fetch.delete();
    push_seq(5);
    exp_reg(6'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    exp_reg(6'd3, 64'd2);
    exp_reg(6'd4, 64'd0);
    release_rst();
    run_halt(400, cyc);
    chk("rw_cycles", cyc, 20);
    chk("rw_instret_end", instret, 5);
    chk("rw_fetch_left", exp_fetch.size(), 0);
    check_sb();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mips_multicycle.md
Name: mips_multicycle

Overview:
- Parametrised successor of the single-cycle MIPS datapath: a multi-cycle core with a FETCH/DECODE/EXEC/WB state machine.
- Fetches 64-bit instructions over a wait-state-tolerant memory handshake.
- Adds immediate, branch, jump, halt and illegal-op handling, an instruction-retired counter and a debug register read port.
- Sits at the top of the processor subsystem; external instruction memory attaches on the imem_* ports.

Parameters:
- DATA_W, 64, register/ALU data width (power of 2, ≥8).
- ADDR_W, 16, PC and instruction-address width.
- REG_ADDR_W, 6, register-address width, giving 2^REG_ADDR_W registers. Legal range 1..8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address (= PC).
- imem_rdata  in  64  instruction word.
- imem_valid  in  1  imem_rdata valid for the current request.
- dbg_raddr  in  REG_ADDR_W  debug register select.
- dbg_rdata  out  DATA_W  combinational register-file read.
- zero  out  1  registered zero flag of last ALU result.
- halted  out  1  core in HALT state.
- illegal  out  1  sticky, undefined opcode seen.
- instret  out  32  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0):
  - State=FETCH, PC=0, imem_req=0.
  - zero=0, halted=0, illegal=0, instret=0, all registers=0.
  - imem_req falls immediately on reset assertion, including mid-fetch.
- Instruction fields (RA=REG_ADDR_W):
  - op=[5:0], rd=[6+:RA], rs1=[6+RA+:RA], rs2=[6+2RA+:RA].
  - imm=[63:32], sign-extended to DATA_W. Bits [31:6+3RA] are ignored.
- FETCH:
  - imem_req=1, imem_addr=PC, held stable until imem_valid=1.
  - On the valid cycle, latch IR and go to DECODE.
  - imem_valid while imem_req=0 is ignored.
- DECODE: latch A=R[rs1], B=R[rs2] → EXEC.
- EXEC: compute the result or branch target into a register → WB.
- WB: write rd, update PC/zero/instret → FETCH.
- Latency: 4 cycles per instruction with zero wait states; each wait cycle adds 1.
- Opcodes and effects (WB always retires: instret+1, 32-bit wrap):
  - 0 NOP: PC+1.
  - 1 ADD, 2 SUB: modulo 2^DATA_W.
  - 3 AND, 4 OR, 5 XOR.
  - 6 SLT: signed, result 1/0.
  - 7 SLL, 8 SRL: shift A by B[log2(DATA_W)-1:0]; upper bits of B ignored.
  - 9 ADDI: A + sext(imm).
  - For opcodes 1-9: R[rd]<=result, zero<=(result==0), PC<=PC+1.
  - 10 BEQ: if A==B then PC<=PC+imm[ADDR_W-1:0], else PC+1. No register write; zero unchanged.
  - 11 JMP: PC<=imm[ADDR_W-1:0].
  - 63 HALT: retire, go to HALT. PC stays at the HALT address, imem_req=0, halted=1. Remains there until reset.
  - Any other opcode: behaves as NOP and sets illegal=1 (sticky until reset).
- PC arithmetic is modulo 2^ADDR_W; e.g. PC=0xFFFF + 1 → 0x0000.
- Register 0 reads 0 always. Writes to rd=0 are discarded but still update zero from the computed result.
- dbg_rdata reflects the pre-edge value during the WB cycle; the new value is visible the cycle after.
- rd==rs1 (e.g. ADD r3,r3,r3) uses the operands latched in DECODE; no hazard exists.

Test Plan:
1. Reset then program at 0 with 0-wait memory:
   - Program: ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; SUB r4,r2,r2; HALT.
   - Required: r1=5, r2=0xFFFF_FFFF_FFFF_FFFD, r3=2, r4=0, zero=1.
   - halted=1 exactly 20 cycles after reset release; instret=5.
2. Same program with a random 0-3 wait-cycle imem_valid:
   - imem_addr stable while imem_req=1; identical final registers.
   - Cycle count = 20 + total wait cycles.
3. Branches and wrap:
   - BEQ r0,r0,imm=-1 at PC=0 → next fetch at 0xFFFF.
   - BEQ with r1≠r2 → PC+1.
   - JMP imm=0x1234 → imem_addr=0x1234.
   - zero is unchanged across all of these.
4. r0 and shifts:
   - ADDI r0,r0,7 → dbg r0 reads 0, zero=0.
   - SLL r5,r1,r6 with r1=1, r6=0x41 → r5=2 (shift masked to 1).
   - SRL/SLT: SLT of -1 vs 1 → 1.
5. Illegal op 0x20:
   - illegal=1, no register change, PC+1, instret+1.
   - illegal stays 1 through later legal instructions.
6. Reset mid-operation:
   - Assert rst_n=0 during a FETCH wait and again during WB.
   - Required: imem_req drops in the same cycle; after release, fetch from 0; all registers and instret read 0.
